// File: rtl/pls_pkg.sv
// rtl/pls_pkg.sv - shared state encoding and widths for the carrier filter
package pls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ON_PEND  = 2'd1,
    ST_CARRIER  = 2'd2,
    ST_OFF_PEND = 2'd3
  } ch_state_t;

  localparam int RUN_W = 4;
  localparam int EVT_W = 8;
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

endpackage

// File: rtl/pls_carrier_filter_if.sv
// rtl/pls_carrier_filter_if.sv - carrier sense inputs and filtered indications
interface pls_carrier_filter_if #(
  parameter int NCH = 4
) ();

  logic [NCH-1:0]   crs;
  logic             cnt_clr;
  logic [NCH-1:0]   pls_carrier_indication;
  logic [NCH-1:0]   carrier_on;
  logic [NCH-1:0]   carrier_off;
  logic [8*NCH-1:0] carrier_cnt;

  modport master (
    output crs, cnt_clr,
    input  pls_carrier_indication, carrier_on, carrier_off, carrier_cnt
  );

  modport slave (
    input  crs, cnt_clr,
    output pls_carrier_indication, carrier_on, carrier_off, carrier_cnt
  );

endinterface

// File: rtl/carrier_filter_ch.sv
// rtl/carrier_filter_ch.sv - one channel: synchronizer, debounce FSM, edge pulses, event counter
module carrier_filter_ch
  import pls_pkg::*;
#(
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             crs,
  input  logic             cnt_clr,
  output logic             indication,
  output logic             carrier_on,
  output logic             carrier_off,
  output logic [EVT_W-1:0] carrier_cnt
);

  localparam logic [RUN_W-1:0] ON_N  = RUN_W'(ON_CYCLES);
  localparam logic [RUN_W-1:0] OFF_N = RUN_W'(OFF_CYCLES);

  logic             sync1_q, sync2_q;
  ch_state_t        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             ind_q, ind_d;
  logic             on_q, on_d;
  logic             off_q, off_d;
  logic [EVT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          if (ON_CYCLES == 1) begin
            state_d = ST_CARRIER;
            run_d   = '0;
          end else begin
            state_d = ST_ON_PEND;
            run_d   = RUN_W'(1);
          end
        end
      end
      ST_ON_PEND: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end else if (run_q + RUN_W'(1) == ON_N) begin
          state_d = ST_CARRIER;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      ST_CARRIER: begin
        if (!sync2_q) begin
          if (OFF_CYCLES == 1) begin
            state_d = ST_IDLE;
            run_d   = '0;
          end else begin
            state_d = ST_OFF_PEND;
            run_d   = RUN_W'(1);
          end
        end
      end
      ST_OFF_PEND: begin
        if (sync2_q) begin
          state_d = ST_CARRIER;
          run_d   = '0;
        end else if (run_q + RUN_W'(1) == OFF_N) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
    endcase

    // Outputs are derived from the next state so they register alongside it.
    ind_d = (state_d == ST_CARRIER) || (state_d == ST_OFF_PEND);
    on_d  = ind_d & ~ind_q;
    off_d = ~ind_d & ind_q;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (on_d && (cnt_q != EVT_MAX)) begin
      cnt_d = cnt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      run_q   <= '0;
      ind_q   <= 1'b0;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= crs;
      sync2_q <= sync1_q;
      state_q <= state_d;
      run_q   <= run_d;
      ind_q   <= ind_d;
      on_q    <= on_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  assign indication  = ind_q;
  assign carrier_on  = on_q;
  assign carrier_off = off_q;
  assign carrier_cnt = cnt_q;

endmodule

// File: rtl/pls_carrier_filter.sv
// rtl/pls_carrier_filter.sv - NCH independent carrier-sense filter channels
module pls_carrier_filter
  import pls_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  pls_carrier_filter_if.slave bus
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    carrier_filter_ch #(
      .ON_CYCLES  (ON_CYCLES),
      .OFF_CYCLES (OFF_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset_L     (reset_L),
      .crs         (bus.crs[i]),
      .cnt_clr     (bus.cnt_clr),
      .indication  (bus.pls_carrier_indication[i]),
      .carrier_on  (bus.carrier_on[i]),
      .carrier_off (bus.carrier_off[i]),
      .carrier_cnt (bus.carrier_cnt[EVT_W*i +: EVT_W])
    );
  end

endmodule

// File: tb/tb_pls_carrier_filter.sv
// tb/tb_pls_carrier_filter.sv - directed and randomized checks against a run-length reference model
module tb_pls_carrier_filter;

  localparam int NCH = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  pls_carrier_filter_if #(.NCH(NCH)) bus ();

  pls_carrier_filter #(.NCH(NCH), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: sample seen by the filter is crs delayed two edges; the indication
  // flips once the sample has disagreed with it for a threshold-long run.
  bit m_h1 [NCH];
  bit m_h2 [NCH];
  bit m_ind [NCH];
  int m_run [NCH];
  bit m_on [NCH];
  bit m_off [NCH];
  int m_cnt [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_h1[c] = 0; m_h2[c] = 0; m_ind[c] = 0; m_run[c] = 0;
      m_on[c] = 0; m_off[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0]   e_ind, e_on, e_off;
    logic [8*NCH-1:0] e_cnt;
    for (int c = 0; c < NCH; c++) begin
      e_ind[c] = m_ind[c];
      e_on[c]  = m_on[c];
      e_off[c] = m_off[c];
      e_cnt[8*c +: 8] = 8'(m_cnt[c]);
    end
    check("indication", 32'(bus.pls_carrier_indication), 32'(e_ind));
    check("carrier_on", 32'(bus.carrier_on), 32'(e_on));
    check("carrier_off", 32'(bus.carrier_off), 32'(e_off));
    check("carrier_cnt", 32'(bus.carrier_cnt), 32'(e_cnt));
    check("on_off_excl", 32'(bus.carrier_on & bus.carrier_off), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_L) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit s, prev;
        int thr;
        s = m_h2[c];
        m_h2[c] = m_h1[c];
        m_h1[c] = bus.crs[c];
        prev = m_ind[c];
        thr = prev ? OFF : ON;
        if (s != prev) begin
          m_run[c]++;
          if (m_run[c] >= thr) begin
            m_ind[c] = ~prev;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_on[c]  = m_ind[c] & ~prev;
        m_off[c] = ~m_ind[c] & prev;
        if (bus.cnt_clr) m_cnt[c] = 0;
        else if (m_on[c] && m_cnt[c] < 255) m_cnt[c]++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    bus.crs = '0;
    bus.cnt_clr = 1'b0;
    model_reset();
    ticks(3);
    check("reset_ind", 32'(bus.pls_carrier_indication), 32'd0);
    check("reset_cnt", 32'(bus.carrier_cnt), 32'd0);
    reset_L = 1'b1;
    ticks(3);

    // Single channel assertion latency: rises on the fifth edge.
    bus.crs[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k < 5) check("lat_on_low", 32'(bus.pls_carrier_indication[0]), 32'd0);
      if (k == 5) check("lat_on_rise", 32'(bus.carrier_on[0]), 32'd1);
      if (k >= 5) check("lat_on_high", 32'(bus.pls_carrier_indication[0]), 32'd1);
      if (k > 5) check("on_single", 32'(bus.carrier_on[0]), 32'd0);
    end
    check("cnt0_one", 32'(bus.carrier_cnt[7:0]), 32'd1);
    check("others_idle", 32'(bus.pls_carrier_indication[3:1]), 32'd0);
    bus.crs[0] = 1'b0;
    ticks(6);

    // Short pulse is filtered; short dropout during carrier is filtered.
    bus.crs[1] = 1'b1;
    ticks(2);
    bus.crs[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("glitch_on", 32'(bus.pls_carrier_indication[1]), 32'd0);
    end
    check("glitch_cnt", 32'(bus.carrier_cnt[15:8]), 32'd0);
    bus.crs[1] = 1'b1;
    ticks(8);
    bus.crs[1] = 1'b0;
    tick();
    check("dropout_hold0", 32'(bus.pls_carrier_indication[1]), 32'd1);
    bus.crs[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("dropout_hold", 32'(bus.pls_carrier_indication[1]), 32'd1);
    end
    bus.crs[1] = 1'b0;
    ticks(6);

    // All channels together.
    bus.crs = 4'b1111;
    ticks(4);
    check("all_pre", 32'(bus.pls_carrier_indication), 32'h0);
    tick();
    check("all_rise", 32'(bus.pls_carrier_indication), 32'hF);
    check("all_on", 32'(bus.carrier_on), 32'hF);
    ticks(3);
    bus.crs = 4'b0000;
    ticks(3);
    check("all_hold", 32'(bus.pls_carrier_indication), 32'hF);
    tick();
    check("all_fall", 32'(bus.pls_carrier_indication), 32'h0);
    check("all_off", 32'(bus.carrier_off), 32'hF);
    tick();
    check("all_off_once", 32'(bus.carrier_off), 32'h0);
    ticks(3);

    // Saturation on channel 2, then clear coincident with a rise.
    for (int b = 0; b < 300; b++) begin
      bus.crs[2] = 1'b1;
      ticks(int'($urandom_range(5, 7)));
      bus.crs[2] = 1'b0;
      ticks(int'($urandom_range(4, 6)));
    end
    check("cnt2_sat", 32'(bus.carrier_cnt[23:16]), 32'd255);
    bus.crs[2] = 1'b1;
    ticks(4);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("clr_wins_ind", 32'(bus.pls_carrier_indication[2]), 32'd1);
    check("clr_wins_cnt", 32'(bus.carrier_cnt[23:16]), 32'd0);
    bus.crs[2] = 1'b0;
    ticks(6);

    // Randomized activity on all channels with occasional clears.
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) bus.crs[c] = ~bus.crs[c];
      bus.cnt_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.cnt_clr = 1'b0;
    bus.crs = 4'b1000;
    ticks(8);
    check("ch3_carrier", 32'(bus.pls_carrier_indication[3]), 32'd1);

    // Asynchronous reset mid-carrier, then full-latency restart.
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check("arst_ind", 32'(bus.pls_carrier_indication), 32'd0);
    check("arst_off", 32'(bus.carrier_off), 32'd0);
    check("arst_cnt", 32'(bus.carrier_cnt), 32'd0);
    @(negedge clk);
    ticks(2);
    reset_L = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("rst_off_pulse", 32'(bus.carrier_off[3]), 32'd0);
      if (k < 5) check("rst_relat_low", 32'(bus.pls_carrier_indication[3]), 32'd0);
      else       check("rst_relat_rise", 32'(bus.pls_carrier_indication[3]), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
